instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch stage directly downstream of the PC register. It takes the current PC value and issues one request to instruction memory. It captures the returned word and presents it to decode with a valid/ready handshake. It drives the PC write-enable, so the PC advances only after decode accepts an instruction or a redirect occurs.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
DATA_W, 32, instruction word width
TIMEOUT, 16, max WAIT/DRAIN cycles before fetch_err (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
pc_in  in  ADDR_W  current PC value from the PC register output
pc_wre_out  out  1  PC write-enable to the PC register; 1 = PC loads its next value at this edge
flush  in  1  redirect (branch/jump taken); PC next-value mux already selects the target
imem_req  out  1  single-cycle request strobe to instruction memory
imem_addr  out  ADDR_W  request address
imem_rvalid  in  1  read data valid, at least 1 cycle after imem_req
imem_rdata  in  DATA_W  read data
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_out  out  DATA_W  fetched instruction
inst_pc  out  ADDR_W  address of inst_out
fetch_err  out  1  sticky timeout error

Behaviour:
- Reset (reset=0, async): state=REQ; inst_out=0, inst_pc=0, fetch_err=0, timeout counter=0. Outputs derived from state: imem_req, pc_wre_out, inst_valid.
- States: REQ, WAIT, HOLD, DRAIN (plus ERR with the optional feature).
- REQ:
  - imem_req = ~flush; imem_addr = pc_in.
  - If ~flush: latch pc_in into inst_pc, go to WAIT.
  - If flush: no request, pc_wre_out=1, stay in REQ.
- WAIT:
  - imem_rvalid & ~flush: inst_out <= imem_rdata, go to HOLD.
  - imem_rvalid & flush: discard data, pc_wre_out=1, go to REQ.
  - ~imem_rvalid & flush: pc_wre_out=1, go to DRAIN (the outstanding response must be swallowed).
  - Otherwise stay in WAIT.
- HOLD:
  - inst_valid = ~flush; inst_out and inst_pc stay stable.
  - flush: pc_wre_out=1, go to REQ; instruction not delivered. flush has priority over a simultaneous inst_ready.
  - inst_ready & ~flush: handshake completes; pc_wre_out=1 (PC advances this edge), go to REQ.
- DRAIN:
  - imem_rvalid: data discarded, go to REQ.
  - flush: pc_wre_out=1 (new target loaded), stay in DRAIN unless rvalid is also high.
- pc_wre_out = 0 in every case not listed above; the PC is frozen while a fetch is in flight.
- Exactly one outstanding request at a time. imem_rvalid in REQ or HOLD is a protocol violation; it is ignored.
- Minimum throughput: request at cycle N, rvalid N+1, inst_valid N+2, next request N+3 when ready is high at N+2.
- Reset asserted mid-operation aborts immediately. Any late rvalid after reset release lands in REQ and is ignored.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT/DRAIN and increments each cycle there without imem_rvalid.
  - When it reaches TIMEOUT-1 with no rvalid: fetch_err <= 1, state goes to ERR.
  - ERR: imem_req=0, inst_valid=0, pc_wre_out=0; held until reset.
- Undefined: no counter, no ERR state; fetch_err tied 0.

Test Plan:
- Reset release with pc_in=0x00000000, memory returns 0x8C010004 one cycle after req → imem_req at cycle 0 addr 0x0; inst_valid=1 at cycle 2 with inst_out=0x8C010004, inst_pc=0x0.
- Back-to-back fetches, inst_ready held 1, 1-cycle memory, PC incrementing by 4 → one pc_wre_out pulse and one instruction every 3 cycles; addresses 0x0, 0x4, 0x8 in order.
- inst_ready=0 for 5 cycles in HOLD → inst_out/inst_pc stable, pc_wre_out=0, no imem_req throughout.
- flush in WAIT, rvalid arrives 3 cycles later with 0xDEADBEEF, pc_in then 0x40 → 0xDEADBEEF never appears with inst_valid=1; next request addr=0x40 after DRAIN.
- flush and inst_ready both high in HOLD → inst_valid=0 that cycle, pc_wre_out=1, next state REQ.
- FETCH_TIMEOUT_EN defined, TIMEOUT=16, memory never responds → fetch_err=1 after 16 WAIT cycles and stays 1; imem_req stays 0 until reset=0.

Source files
------------

// File: rtl/instr_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : instr_fetch_if                                            |
// | Purpose  : Instruction-memory request bus and decode handshake.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface instr_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    output imem_rvalid, imem_rdata, inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : instr_fetch                                               |
// | Purpose  : One-outstanding-request fetch stage between the PC        |
// |            register and decode. Optional FETCH_TIMEOUT_EN adds a     |
// |            response watchdog with a sticky fetch_err.                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module instr_fetch #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic              pc_wre_out,
  output logic              fetch_err,
  instr_fetch_if.master     bus
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3
`ifdef FETCH_TIMEOUT_EN
    , S_ERR = 3'd4
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] inst_out_q, inst_out_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              req;
  logic              valid;
  logic              pc_wre;

`ifdef FETCH_TIMEOUT_EN
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             fetch_err_q, fetch_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    inst_out_d = inst_out_q;
    inst_pc_d  = inst_pc_q;
    req        = 1'b0;
    valid      = 1'b0;
    pc_wre     = 1'b0;

    case (state_q)
      S_REQ: begin
        req = ~flush;
        if (flush) begin
          pc_wre = 1'b1;
        end else begin
          inst_pc_d = pc_in;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          if (flush) begin
            pc_wre  = 1'b1;
            state_d = S_REQ;
          end else begin
            inst_out_d = bus.imem_rdata;
            state_d    = S_HOLD;
          end
        end else if (flush) begin
          // The request is still in flight; its response must be swallowed.
          pc_wre  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        // A redirect wins over a same-cycle accept: the instruction is dropped.
        valid = ~flush;
        if (flush || bus.inst_ready) begin
          pc_wre  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        pc_wre = flush;
        if (bus.imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

`ifdef FETCH_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    fetch_err_d = fetch_err_q;
    if ((state_q == S_WAIT || state_q == S_DRAIN) && !bus.imem_rvalid) begin
      if (tmo_cnt_q == CNT_LAST) begin
        fetch_err_d = 1'b1;
        state_d     = S_ERR;
      end else begin
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      end
    end
    if ((state_d != state_q) && (state_d == S_WAIT || state_d == S_DRAIN)) begin
      tmo_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      inst_out_q <= '0;
      inst_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      inst_out_q <= inst_out_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q   <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign pc_wre_out     = pc_wre;
  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_in;
  assign bus.inst_valid = valid;
  assign bus.inst_out   = inst_out_q;
  assign bus.inst_pc    = inst_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run against a transaction-level model of the fetch protocol.
module tb_instr_fetch;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] pc_in = '0;
  logic              pc_wre_out;
  logic              fetch_err;
  int                checks   = 0;
  int                failures = 0;

  instr_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .flush      (flush),
    .pc_wre_out (pc_wre_out),
    .fetch_err  (fetch_err),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  task automatic apply_reset(input logic [31:0] pc);
    reset = 1'b0; flush = 1'b0; pc_in = pc;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  // Stimulus only: from REQ, return mem_word(pc_in) after one cycle, ending in HOLD.
  task automatic drive_to_hold();
    @(posedge clk); #1 bus.imem_rvalid = 1'b1; bus.imem_rdata = mem_word(pc_in);
    @(posedge clk); #1 bus.imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; pc_in = '0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", bus.inst_valid); end
    checks++; if (bus.inst_out !== 32'h0) begin failures++; $display("FAIL rst_inst_out got=%h exp=0", bus.inst_out); end
    checks++; if (bus.inst_pc !== 32'h0) begin failures++; $display("FAIL rst_inst_pc got=%h exp=0", bus.inst_pc); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", fetch_err); end
    checks++; if (pc_wre_out !== 1'b0) begin failures++; $display("FAIL rst_wre got=%0h exp=0", pc_wre_out); end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%0h exp=1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr got=%h exp=0", bus.imem_addr); end
    @(posedge clk); #1 bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h8C010004;
    @(negedge clk);
    checks++; if ({bus.imem_req, bus.inst_valid, pc_wre_out} !== 3'b000) begin failures++; $display("FAIL first_wait got=%b exp=000", {bus.imem_req, bus.inst_valid, pc_wre_out}); end
    @(posedge clk); #1 bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%0h exp=1", bus.inst_valid); end
    checks++; if (bus.inst_out !== 32'h8C010004) begin failures++; $display("FAIL first_inst got=%h exp=8c010004", bus.inst_out); end
    checks++; if (bus.inst_pc !== 32'h0) begin failures++; $display("FAIL first_pc got=%h exp=0", bus.inst_pc); end
    checks++; if (pc_wre_out !== 1'b1) begin failures++; $display("FAIL first_wre got=%0h exp=1", pc_wre_out); end
    @(posedge clk); #1 bus.inst_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset(32'h0);
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({bus.imem_req, pc_wre_out} !== 2'b10) begin failures++; $display("FAIL b2b_req[%0d] got=%b exp=10", k, {bus.imem_req, pc_wre_out}); end
      checks++; if (bus.imem_addr !== 32'(4 * k)) begin failures++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", k, bus.imem_addr, 4 * k); end
      @(posedge clk); #1 bus.imem_rvalid = 1'b1; bus.imem_rdata = mem_word(32'(4 * k));
      @(negedge clk);
      checks++; if ({bus.imem_req, bus.inst_valid, pc_wre_out} !== 3'b000) begin failures++; $display("FAIL b2b_wait[%0d] got=%b exp=000", k, {bus.imem_req, bus.inst_valid, pc_wre_out}); end
      @(posedge clk); #1 bus.imem_rvalid = 1'b0;
      @(negedge clk);
      checks++; if ({bus.inst_valid, pc_wre_out, bus.imem_req} !== 3'b110) begin failures++; $display("FAIL b2b_hold[%0d] got=%b exp=110", k, {bus.inst_valid, pc_wre_out, bus.imem_req}); end
      checks++; if (bus.inst_out !== mem_word(32'(4 * k))) begin failures++; $display("FAIL b2b_inst[%0d] got=%h exp=%h", k, bus.inst_out, mem_word(32'(4 * k))); end
      checks++; if (bus.inst_pc !== 32'(4 * k)) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", k, bus.inst_pc, 4 * k); end
      @(posedge clk); #1 pc_in = pc_in + 32'd4;
    end
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    apply_reset(32'h24);
    drive_to_hold();
    for (int i = 0; i < 5; i++) begin
      // A stray rvalid while holding must not disturb the held word.
      bus.imem_rvalid = (i == 2); bus.imem_rdata = 32'h12345678;
      @(negedge clk);
      checks++; if ({bus.inst_valid, pc_wre_out, bus.imem_req} !== 3'b100) begin failures++; $display("FAIL stall_ctl[%0d] got=%b exp=100", i, {bus.inst_valid, pc_wre_out, bus.imem_req}); end
      checks++; if (bus.inst_out !== mem_word(32'h24)) begin failures++; $display("FAIL stall_inst[%0d] got=%h exp=%h", i, bus.inst_out, mem_word(32'h24)); end
      checks++; if (bus.inst_pc !== 32'h24) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=24", i, bus.inst_pc); end
      @(posedge clk); #1;
    end
    bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b1;
    @(negedge clk);
    checks++; if (pc_wre_out !== 1'b1) begin failures++; $display("FAIL stall_accept got=%0h exp=1", pc_wre_out); end
    @(posedge clk); #1 bus.inst_ready = 1'b0; pc_in = 32'h28;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h28) begin failures++; $display("FAIL stall_next got=%0h/%h exp=1/28", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_flush_wait_drain();
    apply_reset(32'h20);
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin failures++; $display("FAIL fwd_req got=%0h/%h exp=1/20", bus.imem_req, bus.imem_addr); end
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    checks++; if ({bus.imem_req, pc_wre_out, bus.inst_valid} !== 3'b010) begin failures++; $display("FAIL fwd_flush got=%b exp=010", {bus.imem_req, pc_wre_out, bus.inst_valid}); end
    @(posedge clk); #1 flush = 1'b0; pc_in = 32'h40;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if ({bus.imem_req, pc_wre_out, bus.inst_valid} !== 3'b000) begin failures++; $display("FAIL fwd_drain[%0d] got=%b exp=000", i, {bus.imem_req, pc_wre_out, bus.inst_valid}); end
      @(posedge clk); #1;
    end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin failures++; $display("FAIL fwd_stale got=%b exp=00", {bus.imem_req, bus.inst_valid}); end
    @(posedge clk); #1 bus.imem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin failures++; $display("FAIL fwd_retarget got=%0h/%h exp=1/40", bus.imem_req, bus.imem_addr); end
    @(posedge clk); #1 bus.imem_rvalid = 1'b1; bus.imem_rdata = mem_word(32'h40);
    @(posedge clk); #1 bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_out !== mem_word(32'h40) || bus.inst_pc !== 32'h40) begin failures++; $display("FAIL fwd_deliver got=%0h/%h/%h exp=1/%h/40", bus.inst_valid, bus.inst_out, bus.inst_pc, mem_word(32'h40)); end
    @(posedge clk); #1 bus.inst_ready = 1'b0;
  endtask

  task automatic test_flush_ready_hold();
    apply_reset(32'h60);
    drive_to_hold();
    flush = 1'b1; bus.inst_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.inst_valid, pc_wre_out} !== 2'b01) begin failures++; $display("FAIL frh_ctl got=%b exp=01", {bus.inst_valid, pc_wre_out}); end
    @(posedge clk); #1 flush = 1'b0; bus.inst_ready = 1'b0; pc_in = 32'h80;
    @(negedge clk);
    checks++; if ({bus.imem_req, bus.inst_valid} !== 2'b10 || bus.imem_addr !== 32'h80) begin failures++; $display("FAIL frh_next got=%b/%h exp=10/80", {bus.imem_req, bus.inst_valid}, bus.imem_addr); end
  endtask

  task automatic test_reset_midop();
    apply_reset(32'h30);
    drive_to_hold();
    @(negedge clk); #2 reset = 1'b0; #1;
    checks++; if ({bus.inst_valid, pc_wre_out} !== 2'b00 || bus.inst_out !== 32'h0 || bus.inst_pc !== 32'h0) begin failures++; $display("FAIL midrst got=%b/%h/%h exp=00/0/0", {bus.inst_valid, pc_wre_out}, bus.inst_out, bus.inst_pc); end
    @(posedge clk); #1 reset = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL midrst_req got=%0h exp=1", bus.imem_req); end
    @(posedge clk); #1 bus.imem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin failures++; $display("FAIL midrst_late got=%b exp=00", {bus.imem_req, bus.inst_valid}); end
    @(posedge clk); #1 bus.imem_rvalid = 1'b1; bus.imem_rdata = mem_word(32'h30);
    @(posedge clk); #1 bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_out !== mem_word(32'h30)) begin failures++; $display("FAIL midrst_inst got=%0h/%h exp=1/%h", bus.inst_valid, bus.inst_out, mem_word(32'h30)); end
    @(posedge clk); #1 bus.inst_ready = 1'b0;
  endtask

  // Protocol-level model: a request is outstanding, possibly marked for
  // discard, or an instruction is held for decode; otherwise the stage is idle.
  task automatic test_random();
    logic [31:0] pc, req_pc, paddr;
    bit          busy, drop, held, pending, issue, rv;
    bit          e_req, e_valid, e_wre;
    int          cnt, delivered;
    pc = $urandom & 32'hFFFF_FFFC;
    apply_reset(pc);
    busy = 0; drop = 0; held = 0; pending = 0; cnt = 0; paddr = '0; req_pc = '0; delivered = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      rv = 0; bus.imem_rdata = $urandom;
      if (pending) begin
        if (cnt == 0) begin rv = 1; bus.imem_rdata = mem_word(paddr); pending = 0; end
        else cnt--;
      end else if (!busy && $urandom_range(0, 15) == 0) begin
        rv = 1;
      end
      bus.imem_rvalid = rv;
      flush = ($urandom_range(0, 7) == 0);
      bus.inst_ready = $urandom_range(0, 1) == 1;
      pc_in = pc;
      @(negedge clk);
      e_req = 0; e_valid = 0; e_wre = 0; issue = 0;
      if (held) begin
        e_valid = !flush;
        e_wre   = flush || bus.inst_ready;
      end else if (!busy) begin
        e_req = !flush; e_wre = flush; issue = !flush;
      end else if (drop) begin
        e_wre = flush;
      end else begin
        e_wre = flush;
      end
      checks++; if (bus.imem_req !== e_req) begin failures++; $display("FAIL rnd_req@%0d got=%0h exp=%0h", cyc, bus.imem_req, e_req); end
      checks++; if (bus.inst_valid !== e_valid) begin failures++; $display("FAIL rnd_valid@%0d got=%0h exp=%0h", cyc, bus.inst_valid, e_valid); end
      checks++; if (pc_wre_out !== e_wre) begin failures++; $display("FAIL rnd_wre@%0d got=%0h exp=%0h", cyc, pc_wre_out, e_wre); end
      checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL rnd_err@%0d got=%0h exp=0", cyc, fetch_err); end
      if (e_req) begin
        checks++; if (bus.imem_addr !== pc) begin failures++; $display("FAIL rnd_addr@%0d got=%h exp=%h", cyc, bus.imem_addr, pc); end
      end
      if (e_valid) begin
        checks++; if (bus.inst_pc !== req_pc || bus.inst_out !== mem_word(req_pc)) begin failures++; $display("FAIL rnd_inst@%0d got=%h/%h exp=%h/%h", cyc, bus.inst_pc, bus.inst_out, req_pc, mem_word(req_pc)); end
        if (bus.inst_ready) delivered++;
      end
      // Advance the model.
      if (held) begin
        if (flush || bus.inst_ready) held = 0;
      end else if (!busy) begin
        if (issue) begin busy = 1; drop = 0; req_pc = pc; end
      end else if (drop) begin
        if (rv) begin busy = 0; drop = 0; end
      end else if (rv) begin
        busy = 0; held = !flush;
      end else if (flush) begin
        drop = 1;
      end
      if (issue) begin pending = 1; cnt = $urandom_range(0, 2); paddr = pc; end
      if (e_wre) pc = flush ? ($urandom & 32'hFFFF_FFFC) : pc + 32'd4;
      @(posedge clk); #1;
    end
    flush = 1'b0; bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b0;
    checks++; if (delivered < 20) begin failures++; $display("FAIL rnd_delivered got=%0d exp>=20", delivered); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset(32'h100);
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL tmo_req got=%0h exp=1", bus.imem_req); end
    @(posedge clk); #1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      checks++; if ({fetch_err, bus.imem_req} !== 2'b00) begin failures++; $display("FAIL tmo_wait[%0d] got=%b exp=00", i, {fetch_err, bus.imem_req}); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      flush = (i == 1); bus.inst_ready = 1'b1;
      @(negedge clk);
      checks++; if ({fetch_err, bus.imem_req, pc_wre_out, bus.inst_valid} !== 4'b1000) begin failures++; $display("FAIL tmo_err[%0d] got=%b exp=1000", i, {fetch_err, bus.imem_req, pc_wre_out, bus.inst_valid}); end
      @(posedge clk); #1;
    end
    flush = 1'b0; bus.inst_ready = 1'b0; reset = 1'b0; #1;
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%0h exp=0", fetch_err); end
    @(posedge clk); #1 reset = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_hold_stall();
    test_flush_wait_drain();
    test_flush_ready_hold();
    test_reset_midop();
    test_random();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
